// File: rtl/gradient_pipeline.sv
// Three-stage 3x3 gradient engine: S1 forms signed gx/gy from the selected
// column kernel, S2 takes magnitudes and keeps the signs, S3 combines them
// into a saturated magnitude plus a quantised direction. The whole pipe
// advances in lock-step whenever the output register is empty or drained.
module gradient_pipeline #(
  parameter int PIX_W = 8,
  parameter int MAG_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] p00,
  input  logic [PIX_W-1:0] p01,
  input  logic [PIX_W-1:0] p02,
  input  logic [PIX_W-1:0] p10,
  input  logic [PIX_W-1:0] p11,
  input  logic [PIX_W-1:0] p12,
  input  logic [PIX_W-1:0] p20,
  input  logic [PIX_W-1:0] p21,
  input  logic [PIX_W-1:0] p22,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       kernel_sel,
  input  logic             mag_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAG_W-1:0] grad_mag,
  output logic [1:0]       grad_dir,
  output logic [CNT_W-1:0] sat_count,
  input  logic             sat_clr
);

  localparam int G_W = PIX_W + 6;  // signed gradient width
  localparam int A_W = PIX_W + 5;  // absolute gradient width
  localparam int M_W = PIX_W + 7;  // combined magnitude width, never overflows
  localparam logic [M_W-1:0]   MAG_LIM = M_W'(1'b1) << MAG_W;
  localparam logic [MAG_W-1:0] MAG_MAX = {MAG_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Pixel is unsigned; widen with zeros so the subtraction is exact.
  function automatic logic signed [G_W-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({6'b000000, p});
  endfunction

  logic                    adv_s;
  logic signed [G_W-1:0]   wc_s, wm_s, gx_s, gy_s;
  logic                    v1_r, mode1_r;
  logic signed [G_W-1:0]   gx1_r, gy1_r;
  logic [A_W-1:0]          ax_s, ay_s;
  logic                    v2_r, mode2_r, sx2_r, sy2_r;
  logic [A_W-1:0]          ax2_r, ay2_r, mx_s, mn_s;
  logic [M_W-1:0]          m_s;
  logic                    sat_s;
  logic [MAG_W-1:0]        mag_s;
  logic [1:0]              dir_s;
  logic                    out_valid_r, sat3_r;
  logic [MAG_W-1:0]        grad_mag_r;
  logic [1:0]              grad_dir_r;
  logic [CNT_W-1:0]        sat_cnt_r, sat_cnt_s;
  logic                    deliver_s;

  assign adv_s     = ~out_valid_r | out_ready;
  assign in_ready  = adv_s;
  assign deliver_s = out_valid_r & out_ready;
  assign out_valid = out_valid_r;
  assign grad_mag  = grad_mag_r;
  assign grad_dir  = grad_dir_r;
  assign sat_count = sat_cnt_r;

  // S1 combinational: corner/middle weights and the two weighted differences.
  always_comb begin
    wc_s = G_W'(4'd1);
    wm_s = G_W'(4'd2);
    case (kernel_sel)
      2'b01: begin wc_s = G_W'(4'd1); wm_s = G_W'(4'd1);  end
      2'b10: begin wc_s = G_W'(4'd3); wm_s = G_W'(4'd10); end
      default: begin wc_s = G_W'(4'd1); wm_s = G_W'(4'd2); end
    endcase
    gx_s = wc_s * (ext(p02) - ext(p00)) + wm_s * (ext(p12) - ext(p10))
         + wc_s * (ext(p22) - ext(p20));
    gy_s = wc_s * (ext(p00) - ext(p20)) + wm_s * (ext(p01) - ext(p21))
         + wc_s * (ext(p02) - ext(p22));
  end

  // S2 combinational: magnitudes of the registered gradients.
  always_comb begin
    ax_s = gx1_r[G_W-1] ? A_W'(-gx1_r) : A_W'(gx1_r);
    ay_s = gy1_r[G_W-1] ? A_W'(-gy1_r) : A_W'(gy1_r);
  end

  // S3 combinational: magnitude combine, saturation and direction sector.
  always_comb begin
    if (ax2_r >= ay2_r) begin
      mx_s = ax2_r;
      mn_s = ay2_r;
    end else begin
      mx_s = ay2_r;
      mn_s = ax2_r;
    end
    if (mode2_r) begin
      m_s = M_W'(mx_s) + M_W'(mn_s >> 1);
    end else begin
      m_s = M_W'(ax2_r) + M_W'(ay2_r);
    end
    sat_s = (m_s >= MAG_LIM);
    if (sat_s) begin
      mag_s = MAG_MAX;
    end else begin
      mag_s = m_s[MAG_W-1:0];
    end
    if (ay2_r <= (ax2_r >> 1)) begin
      dir_s = 2'b00;
    end else if (ax2_r <= (ay2_r >> 1)) begin
      dir_s = 2'b10;
    end else if (sx2_r == sy2_r) begin
      dir_s = 2'b11;
    end else begin
      dir_s = 2'b01;
    end
  end

  // Saturation counter next value: clear wins but still counts a coincident hit.
  always_comb begin
    sat_cnt_s = sat_cnt_r;
    if (sat_clr) begin
      sat_cnt_s = (deliver_s && sat3_r) ? CNT_W'(1'b1) : '0;
    end else if (deliver_s && sat3_r && (sat_cnt_r != CNT_MAX)) begin
      sat_cnt_s = sat_cnt_r + CNT_W'(1'b1);
    end else begin
      sat_cnt_s = sat_cnt_r;
    end
  end

  // Pipeline registers: every stage moves together on adv, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r        <= 1'b0;
      mode1_r     <= 1'b0;
      gx1_r       <= '0;
      gy1_r       <= '0;
      v2_r        <= 1'b0;
      mode2_r     <= 1'b0;
      sx2_r       <= 1'b0;
      sy2_r       <= 1'b0;
      ax2_r       <= '0;
      ay2_r       <= '0;
      out_valid_r <= 1'b0;
      sat3_r      <= 1'b0;
      grad_mag_r  <= '0;
      grad_dir_r  <= 2'b00;
    end else if (adv_s) begin
      v1_r        <= in_valid;
      mode1_r     <= mag_mode;
      gx1_r       <= gx_s;
      gy1_r       <= gy_s;
      v2_r        <= v1_r;
      mode2_r     <= mode1_r;
      sx2_r       <= gx1_r[G_W-1];
      sy2_r       <= gy1_r[G_W-1];
      ax2_r       <= ax_s;
      ay2_r       <= ay_s;
      out_valid_r <= v2_r;
      sat3_r      <= sat_s;
      grad_mag_r  <= mag_s;
      grad_dir_r  <= dir_s;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Delivered-saturation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_r <= '0;
    end else begin
      sat_cnt_r <= sat_cnt_s;
    end
  end

endmodule

// File: tb/tb_gradient_pipeline.sv
// Scoreboard bench for gradient_pipeline: accepted windows push a model
// result, a monitor pops on each delivery; directed cases pin known values.
module tb_gradient_pipeline;
  localparam int PIX_W = 8;
  localparam int MAG_W = 8;
  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [71:0] win;
  logic        in_valid, in_ready, mag_mode, out_valid, out_ready, sat_clr;
  logic [1:0]  kernel_sel, grad_dir;
  logic [7:0]  grad_mag;
  logic [3:0]  sat_count;

  typedef struct {int mag; int dir; bit sat;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;
  int   sat_model = 0;
  int   rdy_mode = 0;
  bit   rnd_clr = 1'b0;
  bit   clr_force = 1'b0;
  bit   stall = 1'b0;
  bit   deliver, dsat;
  int   hold_mag, hold_dir;

  gradient_pipeline #(.PIX_W(PIX_W), .MAG_W(MAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .p00(win[7:0]),   .p01(win[15:8]),  .p02(win[23:16]),
    .p10(win[31:24]), .p11(win[39:32]), .p12(win[47:40]),
    .p20(win[55:48]), .p21(win[63:56]), .p22(win[71:64]),
    .in_valid(in_valid), .in_ready(in_ready), .kernel_sel(kernel_sel),
    .mag_mode(mag_mode), .out_valid(out_valid), .out_ready(out_ready),
    .grad_mag(grad_mag), .grad_dir(grad_dir), .sat_count(sat_count),
    .sat_clr(sat_clr));

  always #5 clk = ~clk;

  // Reference: straight arithmetic from the kernel and sector rules.
  function automatic exp_t model(input logic [71:0] w, input logic [1:0] ks, input logic md);
    int px[9];
    int wc, wm, gx, gy, ax, ay, m, mx, mn;
    exp_t r;
    for (int i = 0; i < 9; i++) px[i] = int'(w[i*8 +: 8]);
    case (ks)
      2'b01: begin wc = 1; wm = 1; end
      2'b10: begin wc = 3; wm = 10; end
      default: begin wc = 1; wm = 2; end
    endcase
    gx = wc * (px[2] - px[0]) + wm * (px[5] - px[3]) + wc * (px[8] - px[6]);
    gy = wc * (px[0] - px[6]) + wm * (px[1] - px[7]) + wc * (px[2] - px[8]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    mx = (ax > ay) ? ax : ay;
    mn = (ax > ay) ? ay : ax;
    m = md ? (mx + mn / 2) : (ax + ay);
    r.sat = (m >= (1 << MAG_W));
    r.mag = r.sat ? ((1 << MAG_W) - 1) : m;
    if (2 * ay <= ax || ay <= ax / 2) r.dir = (ay <= ax / 2) ? 0 : 1;
    if (ay <= ax / 2) r.dir = 0;
    else if (ax <= ay / 2) r.dir = 2;
    else if ((gx < 0) == (gy < 0)) r.dir = 3;
    else r.dir = 1;
    return r;
  endfunction

  function automatic logic [71:0] pack9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {a8[7:0], a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  function automatic logic [71:0] rnd_win();
    logic [71:0] w;
    int r;
    for (int i = 0; i < 9; i++) begin
      r = int'($urandom_range(0, 3));
      if (r == 0) w[i*8 +: 8] = 8'h00;
      else if (r == 1) w[i*8 +: 8] = 8'hFF;
      else w[i*8 +: 8] = 8'($urandom_range(0, 255));
    end
    return w;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard producer: every accepted window gets its model result queued.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) exp_q.push_back(model(win, kernel_sel, mag_mode));
  end

  // Monitor: handshake rule, stall hold, in-order results, counter model.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      chk("in_ready_rule", int'(in_ready), int'(!out_valid || out_ready));
      chk("sat_count", int'(sat_count), sat_model);
      if (stall) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_mag", int'(grad_mag), hold_mag);
        chk("hold_dir", int'(grad_dir), hold_dir);
      end
      deliver = out_valid && out_ready;
      dsat = 1'b0;
      if (deliver) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got mag %0d, expected no result", grad_mag);
        end else begin
          e = exp_q.pop_front();
          chk("grad_mag", int'(grad_mag), e.mag);
          chk("grad_dir", int'(grad_dir), e.dir);
          dsat = e.sat;
        end
      end
      if (sat_clr) sat_model = (deliver && dsat) ? 1 : 0;
      else if (deliver && dsat && sat_model < (1 << CNT_W) - 1) sat_model++;
      stall = out_valid && !out_ready;
      hold_mag = int'(grad_mag);
      hold_dir = int'(grad_dir);
    end
  end

  // Sole driver of out_ready / sat_clr, applied mid-cycle.
  initial begin
    out_ready = 1'b1;
    sat_clr = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      sat_clr = clr_force || (rnd_clr && $urandom_range(0, 15) == 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [71:0] w, input logic [1:0] ks, input logic md);
    bit ok = 1'b0;
    win = w; kernel_sel = ks; mag_mode = md; in_valid = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got no acceptance, expected one within 200 cycles");
    end
  endtask

  // Idle pipe, out_ready high: checks latency and the delivered values.
  task automatic send_expect(input string name, input logic [71:0] w, input logic [1:0] ks,
                             input logic md, input int emag, input int edir);
    int lat = 0;
    send(w, ks, md);
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      if (out_valid) lat = k;
    end
    chk({name, "_latency"}, lat, 3);
    chk({name, "_mag"}, int'(grad_mag), emag);
    chk({name, "_dir"}, int'(grad_dir), edir);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; win = '0; kernel_sel = 2'b00; mag_mode = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_sat_count", int'(sat_count), 0);
    chk("rst_grad_mag", int'(grad_mag), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    send_expect("sobel_edge", pack9(0, 0, 255, 0, 0, 255, 0, 0, 255), 2'b00, 1'b0, 255, 0);
    chk("sobel_edge_satcnt", int'(sat_count), 1);
    send_expect("prewitt", pack9(0, 0, 10, 0, 0, 10, 0, 0, 10), 2'b01, 1'b0, 30, 0);
    chk("prewitt_satcnt", int'(sat_count), 1);
    send_expect("scharr", pack9(0, 0, 10, 0, 0, 10, 0, 0, 10), 2'b10, 1'b0, 160, 0);
    send_expect("corner_l1", pack9(100, 0, 0, 0, 0, 0, 0, 0, 0), 2'b00, 1'b0, 200, 1);
    send_expect("corner_apx", pack9(100, 0, 0, 0, 0, 0, 0, 0, 0), 2'b00, 1'b1, 150, 1);
    send_expect("ksel11", pack9(100, 0, 0, 0, 0, 0, 0, 0, 0), 2'b11, 1'b0, 200, 1);

    // Continuous stream with a 5-cycle downstream stall.
    fork
      for (int i = 0; i < 12; i++) send(rnd_win(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      begin
        idle(4);
        rdy_mode = 1;
        idle(2);
        chk("stall_out_valid", int'(out_valid), 1);
        chk("stall_in_ready", int'(in_ready), 0);
        idle(3);
        rdy_mode = 0;
      end
    join
    idle(6);

    // Counter sticks at all-ones, then clear coincides with a saturated delivery.
    for (int i = 0; i < 17; i++) send(pack9(0, 0, 255, 0, 0, 255, 0, 0, 255), 2'b00, 1'b0);
    idle(5);
    chk("sat_sticky", int'(sat_count), 15);
    send(pack9(0, 0, 255, 0, 0, 255, 0, 0, 255), 2'b00, 1'b0);
    for (int k = 0; k < 10 && !out_valid; k++) idle(1);
    clr_force = 1'b1;
    idle(1);
    clr_force = 1'b0;
    chk("sat_clr_coincide", int'(sat_count), 1);
    idle(3);

    // Reset with three windows in flight.
    for (int i = 0; i < 3; i++) send(rnd_win(), 2'b10, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_grad_mag", int'(grad_mag), 0);
    chk("midrst_grad_dir", int'(grad_dir), 0);
    chk("midrst_sat_count", int'(sat_count), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    exp_q.delete();
    sat_model = 0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("no_stale", int'(out_valid), 0);
    end
    idle(1);
    send_expect("post_rst", pack9(100, 0, 0, 0, 0, 0, 0, 0, 0), 2'b00, 1'b1, 150, 1);

    // Randomized traffic with random backpressure and clears.
    rdy_mode = 2;
    rnd_clr = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      send(rnd_win(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    rnd_clr = 1'b0;
    rdy_mode = 0;
    for (int k = 0; k < 500 && exp_q.size() > 0; k++) idle(1);
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", exp_q.size());
    end
    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
